unidade_execucao_matriz: RTL and testbench

UNIDADE_EXECUCAO_MATRIZ -- requirements
Module: unidade_execucao_matriz

---
 rtl/unidade_execucao_matriz_pkg.sv | 52 +++++
 rtl/unidade_execucao_matriz_if.sv | 42 ++++
 rtl/unidade_execucao_matriz_decod.sv | 17 +
 rtl/unidade_execucao_matriz.sv | 143 ++++++++++++++
 tb/tb_unidade_execucao_matriz.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_execucao_matriz_pkg.sv
// Shared definitions for the matrix execution unit.
// Holds the default widths, the instruction field positions, the opcode
// constants, the FSM state encoding and the decoded-instruction struct.
// No ports: this is a package imported by the interface, the decoder and the top.
package unidade_execucao_matriz_pkg;

    localparam int DADO_W_PADRAO = 16;
    localparam int ADDR_W_PADRAO = 8;
    localparam int INSTR_W       = 32;
    localparam int IDX_W         = 6;

    // Field positions inside the 32-bit instruction word
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 28;
    localparam int LINHA_MSB  = 27;
    localparam int LINHA_LSB  = 25;
    localparam int COLUNA_MSB = 24;
    localparam int COLUNA_LSB = 22;
    localparam int DADO_MSB   = 21;
    localparam int DADO_LSB   = 6;
    localparam int ID_MSB     = 5;
    localparam int ID_LSB     = 4;

    // Opcodes; 0x5..0xF are illegal
    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_ESCREVER  = 4'h1;
    localparam logic [3:0] OP_LER       = 4'h2;
    localparam logic [3:0] OP_ZERAR     = 4'h3;
    localparam logic [3:0] OP_PREENCHER = 4'h4;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ESCREVE   = 3'd1,
        LE_REQ    = 3'd2,
        LE_ESPERA = 3'd3,
        VARRE     = 3'd4,
        RESPONDE  = 3'd5
    } estado_e;

    typedef struct packed {
        logic [3:0]                   opcode;
        logic [2:0]                   linha;
        logic [2:0]                   coluna;
        logic [DADO_MSB-DADO_LSB:0]   dado;
        logic [1:0]                   id_matriz;
    } instr_campos_t;

    function automatic logic opcode_legal(input logic [3:0] op);
        return (op <= OP_PREENCHER);
    endfunction

endpackage

// File: rtl/unidade_execucao_matriz_if.sv
// Bus bundle of the matrix execution unit: instruction handshake, matrix-bank
// access port and response handshake.
// Ports (as signals): instr_valid/instr_ready/instrucao, mem_en/mem_we/
// mem_addr/mem_wdata/mem_rdata, resp_valid/resp_ready/resp_dado/resp_erro,
// ocupado.
//
// Handshake semantics (both instr_* and resp_*): a transfer happens on a
// rising clock edge where valid and ready are both 1. The producer keeps
// valid and its payload stable until that edge; ready may be raised or
// dropped at any time by the consumer and does not depend on valid.
interface unidade_execucao_matriz_if #(
    parameter int DADO_W = 16,
    parameter int ADDR_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instrucao;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DADO_W-1:0] mem_wdata;
    logic [DADO_W-1:0] mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DADO_W-1:0] resp_dado;
    logic              resp_erro;
    logic              ocupado;

    // Execution unit side
    modport slave (
        input  instr_valid, instrucao, mem_rdata, resp_ready,
        output instr_ready, mem_en, mem_we, mem_addr, mem_wdata,
               resp_valid, resp_dado, resp_erro, ocupado
    );

    // Instruction source / bank / response consumer side
    modport master (
        output instr_valid, instrucao, mem_rdata, resp_ready,
        input  instr_ready, mem_en, mem_we, mem_addr, mem_wdata,
               resp_valid, resp_dado, resp_erro, ocupado
    );
endinterface

// File: rtl/unidade_execucao_matriz_decod.sv
// decodificador_instrucao: purely combinational split of a 32-bit
// instruction word into its fields, plus a legality flag for the opcode.
// Ports: instrucao (in, 32), campos (out, decoded fields), legal (out, 1).
module decodificador_instrucao
    import unidade_execucao_matriz_pkg::*;
(
    input  logic [INSTR_W-1:0] instrucao,
    output instr_campos_t      campos,
    output logic               legal
);
    assign campos.opcode    = instrucao[OP_MSB:OP_LSB];
    assign campos.linha     = instrucao[LINHA_MSB:LINHA_LSB];
    assign campos.coluna    = instrucao[COLUNA_MSB:COLUNA_LSB];
    assign campos.dado      = instrucao[DADO_MSB:DADO_LSB];
    assign campos.id_matriz = instrucao[ID_MSB:ID_LSB];
    assign legal            = opcode_legal(instrucao[OP_MSB:OP_LSB]);
endmodule

// File: rtl/unidade_execucao_matriz.sv
// unidade_execucao_matriz: executes one matrix-bank instruction at a time
// (NOP, single write, single read, 64-entry zero/fill sweep) and returns a
// response with the read data or an illegal-opcode flag.
// Ports: clk, rst_n (async, active-low); bus (slave modport: instruction
// handshake, bank access, response handshake, ocupado); estado_dbg (current
// FSM state, for observation only).
module unidade_execucao_matriz
    import unidade_execucao_matriz_pkg::*;
#(
    parameter int DADO_W = DADO_W_PADRAO,
    parameter int ADDR_W = ADDR_W_PADRAO
) (
    input  logic                          clk,
    input  logic                          rst_n,
    unidade_execucao_matriz_if.slave      bus,
    output estado_e                       estado_dbg
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    estado_e             estado_q, estado_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DADO_W-1:0]   resp_dado_q, resp_dado_d;
    logic                resp_erro_q, resp_erro_d;
    logic                ready_q, ready_d;

    instr_campos_t       campos;
    logic                campos_legal;
    logic                aceita;
    logic [3:0]          op_novo;

    // Operands always come from the registered word
    decodificador_instrucao u_decod (
        .instrucao (instr_q),
        .campos    (campos),
        .legal     (campos_legal)
    );

    assign aceita     = bus.instr_valid & ready_q;
    // Dispatch looks at the opcode of the word being accepted so the first
    // action can happen in the very next cycle.
    assign op_novo    = bus.instrucao[OP_MSB:OP_LSB];
    assign estado_dbg = estado_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            instr_q     <= '0;
            idx_q       <= '0;
            resp_dado_q <= '0;
            resp_erro_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            instr_q     <= instr_d;
            idx_q       <= idx_d;
            resp_dado_q <= resp_dado_d;
            resp_erro_q <= resp_erro_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO: begin
                if (aceita) begin
                    case (op_novo)
                        OP_ESCREVER:            estado_d = ESCREVE;
                        OP_LER:                 estado_d = LE_REQ;
                        OP_ZERAR, OP_PREENCHER: estado_d = VARRE;
                        default:                estado_d = RESPONDE; // NOP and illegal
                    endcase
                end
            end
            ESCREVE:   estado_d = RESPONDE;
            LE_REQ:    estado_d = LE_ESPERA;
            LE_ESPERA: estado_d = RESPONDE;
            VARRE:     if (idx_q == IDX_MAX) estado_d = RESPONDE;
            RESPONDE:  if (bus.resp_ready) estado_d = OCIOSO;
            default:   estado_d = OCIOSO;
        endcase
    end

    // Datapath next values
    always_comb begin
        instr_d     = instr_q;
        idx_d       = idx_q;
        resp_dado_d = resp_dado_q;
        resp_erro_d = resp_erro_q;
        if (estado_q == OCIOSO && aceita) begin
            instr_d     = bus.instrucao;
            resp_dado_d = '0;
            resp_erro_d = ~opcode_legal(op_novo);
        end
        // Sweep index stops at the last entry and is parked back at 0
        if (estado_q == VARRE) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        // Bank returns read data one cycle after the strobe
        if (estado_q == LE_ESPERA) begin
            resp_dado_d = bus.mem_rdata;
        end
        // Registered ready keeps instr_ready low while reset is asserted
        ready_d = (estado_d == OCIOSO);
    end

    // Outputs
    always_comb begin
        bus.instr_ready = ready_q;
        bus.ocupado     = (estado_q != OCIOSO);
        bus.resp_valid  = (estado_q == RESPONDE);
        bus.resp_dado   = (estado_q == RESPONDE) ? resp_dado_q : '0;
        bus.resp_erro   = (estado_q == RESPONDE) ? resp_erro_q : 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        case (estado_q)
            ESCREVE: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = ADDR_W'({campos.id_matriz, campos.linha, campos.coluna});
                bus.mem_wdata = DADO_W'(campos.dado);
            end
            LE_REQ: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = ADDR_W'({campos.id_matriz, campos.linha, campos.coluna});
            end
            VARRE: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = ADDR_W'({campos.id_matriz, idx_q});
                bus.mem_wdata = (campos.opcode == OP_ZERAR) ? '0 : DADO_W'(campos.dado);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_execucao_matriz.sv
// Directed bench for unidade_execucao_matriz with a behavioural bank model,
// a bank-access expectation queue and a response expectation queue.
module tb_unidade_execucao_matriz;
    import unidade_execucao_matriz_pkg::*;

    logic    clk;
    logic    rst_n;
    estado_e estado_dbg;
    int      cyc;
    int      vectors;
    int      miscompares;

    logic [15:0] mem_model [256];
    logic [15:0] ref_mem   [256];
    // {we, cycle[15:0], addr, wdata}
    logic [40:0] exp_mem_q[$];
    // {cycle[15:0], erro, dado}
    logic [32:0] exp_q[$];

    unidade_execucao_matriz_if #(.DADO_W(16), .ADDR_W(8)) bus ();

    unidade_execucao_matriz #(.DADO_W(16), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .estado_dbg (estado_dbg)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: read data valid only in the cycle after the strobe
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem_model[bus.mem_addr] : 16'hDEAD;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check bank activity against the expectation queue
    task automatic tick();
        logic [40:0] obs;
        logic [40:0] e;
        @(negedge clk);
        if (bus.mem_en === 1'b1) begin
            obs = {bus.mem_we, cyc[15:0], bus.mem_addr, bus.mem_we ? bus.mem_wdata : 16'h0};
            if (exp_mem_q.size() == 0) begin
                check("mem_unexpected_strobe", bus.mem_en, 1'b0);
            end else begin
                e = exp_mem_q.pop_front();
                check("mem_access", obs, e);
            end
        end else begin
            check("mem_idle_zero", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'h0);
        end
    endtask

    // Offer one instruction, push its expected effects at acceptance
    task automatic issue(input logic [3:0] op, input logic [1:0] id, input logic [2:0] l,
                         input logic [2:0] c, input logic [15:0] d);
        int n;
        int t;
        logic [7:0] a;
        logic [7:0] sa;
        logic [15:0] wd;
        bus.instrucao   = {op, l, c, d, id, 4'h0};
        bus.instr_valid = 1'b1;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", bus.instr_ready, 1'b1);
        t = cyc;
        a = {id, l, c};
        case (op)
            OP_NOP: exp_q.push_back({16'(t + 1), 1'b0, 16'h0});
            OP_ESCREVER: begin
                exp_mem_q.push_back({1'b1, 16'(t + 1), a, d});
                ref_mem[a] = d;
                exp_q.push_back({16'(t + 2), 1'b0, 16'h0});
            end
            OP_LER: begin
                exp_mem_q.push_back({1'b0, 16'(t + 1), a, 16'h0});
                exp_q.push_back({16'(t + 3), 1'b0, ref_mem[a]});
            end
            OP_ZERAR, OP_PREENCHER: begin
                wd = (op == OP_ZERAR) ? 16'h0 : d;
                for (int i = 0; i < 64; i++) begin
                    sa = {id, 6'(i)};
                    exp_mem_q.push_back({1'b1, 16'(t + 1 + i), sa, wd});
                    ref_mem[sa] = wd;
                end
                exp_q.push_back({16'(t + 65), 1'b0, 16'h0});
            end
            default: exp_q.push_back({16'(t + 1), 1'b1, 16'h0});
        endcase
        tick();
        bus.instr_valid = 1'b0;
    endtask

    // Wait for the response, optionally stall it, then consume it
    task automatic wait_resp(input int stall);
        int n;
        logic [32:0] e;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 100) begin
            check("busy_no_ready", {bus.instr_ready, bus.ocupado}, 2'b01);
            tick();
            n++;
        end
        check("resp_valid_seen", bus.resp_valid, 1'b1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
        check("resp_timing_data", {cyc[15:0], bus.resp_erro, bus.resp_dado}, e);
        check("mem_all_done", exp_mem_q.size(), 0);
        for (int k = 0; k < stall; k++) begin
            bus.instrucao   = {OP_ESCREVER, 3'd1, 3'd1, 16'h7777, 2'd0, 4'h0};
            bus.instr_valid = 1'b1;
            tick();
            check("stall_hold", {bus.resp_valid, bus.instr_ready, bus.ocupado, bus.resp_erro, bus.resp_dado},
                  {3'b101, e[16], e[15:0]});
        end
        bus.instr_valid = 1'b0;
        bus.resp_ready  = 1'b1;
        tick();
        bus.resp_ready  = 1'b0;
        check("idle_after_resp", {bus.instr_ready, bus.resp_valid, bus.ocupado}, 3'b100);
    endtask

    initial begin
        logic [1:0]  rid;
        logic [2:0]  rl;
        logic [2:0]  rc;
        logic [15:0] rd;
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instrucao   = '0;
        bus.resp_ready  = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;

        // Reset state
        #1;
        check("reset_outputs", {bus.instr_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                bus.resp_valid, bus.resp_dado, bus.resp_erro, bus.ocupado}, 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_release", {bus.instr_ready, bus.ocupado}, 2'b10);

        // Single write then read back
        issue(OP_ESCREVER, 2'd2, 3'd3, 3'd5, 16'hBEEF);
        wait_resp(0);
        issue(OP_LER, 2'd2, 3'd3, 3'd5, 16'h0);
        wait_resp(0);

        // NOP and illegal opcodes
        issue(OP_NOP, 2'd0, 3'd0, 3'd0, 16'hFFFF);
        wait_resp(0);
        issue(4'hA, 2'd1, 3'd2, 3'd2, 16'h1111);
        wait_resp(0);
        issue(4'hF, 2'd3, 3'd7, 3'd7, 16'hFFFF);
        wait_resp(0);
        issue(4'h5, 2'd0, 3'd1, 3'd1, 16'h2222);
        wait_resp(0);

        // Fill then zero matrix 1
        issue(OP_PREENCHER, 2'd1, 3'd6, 3'd1, 16'h1234);
        wait_resp(0);
        issue(OP_LER, 2'd1, 3'd7, 3'd7, 16'h0);
        wait_resp(0);
        issue(OP_ZERAR, 2'd1, 3'd2, 3'd4, 16'hFFFF);
        wait_resp(0);
        issue(OP_LER, 2'd1, 3'd0, 3'd0, 16'h0);
        wait_resp(0);

        // Random write/read pairs
        for (int k = 0; k < 6; k++) begin
            rid = 2'($urandom_range(0, 3));
            rl  = 3'($urandom_range(0, 7));
            rc  = 3'($urandom_range(0, 7));
            rd  = 16'($urandom_range(0, 65535));
            issue(OP_ESCREVER, rid, rl, rc, rd);
            wait_resp(0);
            issue(OP_LER, rid, rl, rc, 16'h0);
            wait_resp(0);
        end

        // Response held back for 10 cycles while another instruction is offered
        issue(OP_LER, 2'd2, 3'd3, 3'd5, 16'h0);
        wait_resp(10);

        // Reset in the middle of a sweep, at index 20
        issue(OP_PREENCHER, 2'd3, 3'd0, 3'd0, 16'hA5A5);
        for (int k = 0; k < 20; k++) tick();
        rst_n = 1'b0;
        #1;
        check("reset_mid_sweep", {bus.instr_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                  bus.resp_valid, bus.resp_dado, bus.resp_erro, bus.ocupado}, 64'h0);
        exp_mem_q.delete();
        exp_q.delete();
        tick();
        check("reset_hold_no_resp", {bus.resp_valid, bus.instr_ready}, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_abort", {bus.instr_ready, bus.resp_valid, bus.ocupado}, 3'b100);
        check("state_after_abort", estado_dbg, OCIOSO);
        tick();
        check("no_stale_resp", {bus.resp_valid, bus.ocupado}, 2'b00);

        // Sweep restarts from index 0 after the abort
        issue(OP_PREENCHER, 2'd3, 3'd0, 3'd0, 16'h5A5A);
        wait_resp(0);
        issue(OP_LER, 2'd3, 3'd7, 3'd7, 16'h0);
        wait_resp(0);
        issue(OP_LER, 2'd3, 3'd0, 3'd0, 16'h0);
        wait_resp(0);

        tick();
        check("mem_queue_empty", exp_mem_q.size(), 0);
        check("resp_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
